// File: rtl/inst_queue_pkg.sv
// Shared sizing for the IF->ID instruction queue.
// The optional zero-latency path is enabled by defining IQ_BYPASS_EN.
package inst_queue_pkg;
  localparam int FS_TO_DS_BUS_WD = 109;
  localparam int IQ_DEPTH        = 4;
  localparam int IQ_PTR_WD       = $clog2(IQ_DEPTH);
  localparam int IQ_EXCP_BIT     = 68;
endpackage

// File: rtl/inst_queue_entry_ram.sv
// Queue storage: one synchronous write port and one asynchronous read port.
// The contents are not reset; occupancy tracking in the top qualifies reads.
module iq_entry_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 109,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/inst_queue.sv
// Decoupling FIFO between IF and ID; cleared by flush, blocks after a fetch exception.
// Defining IQ_BYPASS_EN forwards the IF packet straight to ID when the queue is empty.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH    = IQ_DEPTH,
  parameter int BUS_WD   = FS_TO_DS_BUS_WD,
  parameter int EXCP_BIT = IQ_EXCP_BIT
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      fs_to_ds_valid,
  input  logic [BUS_WD-1:0]         fs_to_ds_bus,
  output logic                      iq_allowin,
  output logic                      iq_to_ds_valid,
  output logic [BUS_WD-1:0]         iq_to_ds_bus,
  input  logic                      ds_allowin,
  input  logic                      flush,
  output logic [$clog2(DEPTH):0]    iq_count
);
  localparam int PTR_WD = $clog2(DEPTH);
  localparam int CNT_WD = PTR_WD + 1;

  logic [PTR_WD-1:0] wr_ptr, rd_ptr;
  logic [CNT_WD-1:0] count;
  logic              excp_hold;
  logic              empty, full, push, pop, wr_en, rd_en;
  logic [BUS_WD-1:0] ram_rdata;

  assign empty = (count == '0);
  assign full  = (count == CNT_WD'(DEPTH));

  // Full blocks push even if ID pops this cycle, keeping ds_allowin off the allowin path.
  assign iq_allowin = !full & !excp_hold & !flush;
  assign push       = fs_to_ds_valid & iq_allowin;

`ifdef IQ_BYPASS_EN
  logic bypass;
  assign bypass         = empty & push & ds_allowin;
  assign iq_to_ds_valid = bypass | (!empty & !flush);
  assign iq_to_ds_bus   = bypass ? fs_to_ds_bus : ram_rdata;
  assign wr_en          = push & !bypass;
`else
  assign iq_to_ds_valid = !empty & !flush;
  assign iq_to_ds_bus   = ram_rdata;
  assign wr_en          = push;
`endif

  assign pop   = iq_to_ds_valid & ds_allowin;
  assign rd_en = pop & !empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      excp_hold <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      excp_hold <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_WD'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_WD'(1);
      count <= count + CNT_WD'(wr_en) - CNT_WD'(rd_en);
      // Everything after an exception packet is wrong-path until the flush arrives.
      if (push && fs_to_ds_bus[EXCP_BIT]) excp_hold <= 1'b1;
    end
  end

  assign iq_count = count;

  iq_entry_ram #(.DEPTH(DEPTH), .WIDTH(BUS_WD), .AW(PTR_WD)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (fs_to_ds_bus),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );
endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: fill, wrap, flush, exception hold, async reset, empty latency.
module tb_inst_queue;
  localparam int BW = 109;

  logic          clk = 1'b0;
  logic          resetn;
  logic          fs_to_ds_valid;
  logic [BW-1:0] fs_to_ds_bus;
  logic          iq_allowin;
  logic          iq_to_ds_valid;
  logic [BW-1:0] iq_to_ds_bus;
  logic          ds_allowin;
  logic          flush;
  logic [2:0]    iq_count;

  int n_cmp  = 0;
  int n_fail = 0;

  inst_queue dut (
    .clk            (clk),
    .resetn         (resetn),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .iq_allowin     (iq_allowin),
    .iq_to_ds_valid (iq_to_ds_valid),
    .iq_to_ds_bus   (iq_to_ds_bus),
    .ds_allowin     (ds_allowin),
    .flush          (flush),
    .iq_count       (iq_count)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] pkt(input logic [31:0] pc, input logic excp);
    logic [BW-1:0] p;
    p       = '0;
    p[31:0] = pc;
    p[68]   = excp;
    p[108:100] = pc[10:2];
    return p;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic ex,
                       input logic dsa, input logic fl);
    fs_to_ds_valid = v;
    fs_to_ds_bus   = pkt(pc, ex);
    ds_allowin     = dsa;
    flush          = fl;
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    fs_to_ds_valid = 1'b0;
    fs_to_ds_bus   = '0;
    ds_allowin     = 1'b0;
    flush          = 1'b0;
    #2;
    chk("rst_valid",   iq_to_ds_valid, 0);
    chk("rst_allowin", iq_allowin,     1);
    chk("rst_count",   iq_count,       0);
    #1 resetn = 1'b1;
    tick();

    // 1: fill with ID stalled, fifth packet refused, then in-order drain
    for (int k = 0; k < 5; k++) begin
      drive(1, 32'h1c000000 + 4*k, 0, 0, 0);
      chk($sformatf("fill_allowin%0d", k), iq_allowin, (k < 4) ? 1 : 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    chk("fill_count",   iq_count,   4);
    chk("fill_allowin", iq_allowin, 0);
    for (int j = 0; j < 4; j++) begin
      drive(0, 0, 0, 1, 0);
      chk($sformatf("drain_valid%0d", j), iq_to_ds_valid, 1);
      chk($sformatf("drain_pc%0d", j), iq_to_ds_bus, pkt(32'h1c000000 + 4*j, 0));
      tick();
    end
    drive(0, 0, 0, 0, 0);
    chk("drain_count", iq_count,       0);
    chk("drain_empty", iq_to_ds_valid, 0);

    // 2: two packets preloaded, then steady push+pop across pointer wrap
    for (int k = 0; k < 2; k++) begin
      drive(1, 32'h1c000100 + 4*k, 0, 0, 0);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h1c000108 + 4*i, 0, 1, 0);
      chk($sformatf("wrap_pc%0d", i),    iq_to_ds_bus, pkt(32'h1c000100 + 4*i, 0));
      chk($sformatf("wrap_count%0d", i), iq_count,     2);
      tick();
    end
    for (int j = 0; j < 2; j++) begin
      drive(0, 0, 0, 1, 0);
      chk($sformatf("wrap_tail%0d", j), iq_to_ds_bus, pkt(32'h1c000128 + 4*j, 0));
      tick();
    end
    drive(0, 0, 0, 0, 0);
    chk("wrap_end_count", iq_count, 0);

    // 3: flush at count=3 with a concurrent push
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h1c000200 + 4*k, 0, 0, 0);
      tick();
    end
    drive(1, 32'h1c00020c, 0, 1, 1);
    chk("flush_allowin", iq_allowin,     0);
    chk("flush_valid",   iq_to_ds_valid, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("postflush_count", iq_count,       0);
    chk("postflush_valid", iq_to_ds_valid, 0);
    drive(1, 32'h1c008000, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 0);
    chk("postflush_first", iq_to_ds_bus, pkt(32'h1c008000, 0));
    chk("postflush_cnt1",  iq_count,     1);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("postflush_drained", iq_count, 0);

    // 4: exception packet blocks further pushes until flush
    drive(1, 32'h1c000300, 1, 0, 0);
    tick();
    drive(1, 32'h1c000304, 0, 0, 0);
    chk("excp_allowin", iq_allowin, 0);
    tick();
    drive(1, 32'h1c000304, 0, 0, 0);
    chk("excp_count", iq_count, 1);
    drive(1, 32'h1c000304, 0, 1, 0);
    chk("excp_deliver", iq_to_ds_bus,   pkt(32'h1c000300, 1));
    chk("excp_valid",   iq_to_ds_valid, 1);
    tick();
    drive(1, 32'h1c000304, 0, 1, 0);
    chk("excp_hold_empty", iq_allowin,     0);
    chk("excp_no_bypass",  iq_to_ds_valid, 0);
    drive(0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("excp_cleared", iq_allowin, 1);

    // 5: async reset between edges
    for (int k = 0; k < 2; k++) begin
      drive(1, 32'h1c000500 + 4*k, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    chk("prereset_count", iq_count, 2);
    resetn = 1'b0;
    #1;
    chk("async_valid",   iq_to_ds_valid, 0);
    chk("async_count",   iq_count,       0);
    chk("async_allowin", iq_allowin,     1);
    resetn = 1'b1;
    tick();

    // 6: empty queue latency
    drive(1, 32'h1c000400, 0, 1, 0);
`ifdef IQ_BYPASS_EN
    chk("byp_valid", iq_to_ds_valid, 1);
    chk("byp_bus",   iq_to_ds_bus,   pkt(32'h1c000400, 0));
    tick();
    drive(0, 0, 0, 1, 0);
    chk("byp_count", iq_count,       0);
    chk("byp_after", iq_to_ds_valid, 0);
`else
    chk("lat_same_valid", iq_to_ds_valid, 0);
    tick();
    drive(0, 0, 0, 1, 0);
    chk("lat_count1", iq_count,       1);
    chk("lat_valid",  iq_to_ds_valid, 1);
    chk("lat_bus",    iq_to_ds_bus,   pkt(32'h1c000400, 0));
    tick();
    drive(0, 0, 0, 0, 0);
    chk("lat_count0", iq_count, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
